// File: rtl/pc_unit.sv
// pc_unit
//   Program-counter stage. Chooses the next fetch address from the sequential
//   path (pc + 4), a branch (pc + 4 + imm_sl2), a J-type jump or a register
//   jump, and holds it in the PC register. A one-entry redirect buffer keeps a
//   redirect that was resolved while fetch was stalled, so it is not lost.
//
// Ports
//   clk              in   rising-edge clock
//   rst_n            in   synchronous, active-low reset
//   stall            in   1 = hold pc this cycle
//   branch           in   take branch (lowest priority)
//   jump             in   take J-type jump
//   jr               in   take register jump (highest priority)
//   imm_sl2          in   n-bit branch offset, sign-extended and shifted left 2
//   jaddr            in   26-bit J-type instruction index
//   jr_target        in   n-bit register jump address
//   pc               out  current fetch address (registered)
//   pc_plus4         out  pc + 4 (combinational)
//   fetch_valid      out  registered; pc is a real fetch address
//   redirect_pending out  registered; buffered redirect waiting for stall
//                         release. This flop is also the whole control state
//                         (0 = RUN, 1 = PEND).
//
// Handshake: there is no valid/ready pair. The redirect inputs are sampled at
// every rising edge with rst_n=1; a redirect seen while stall=1 is parked in
// the buffer, and the newest parked redirect wins. A live redirect on the
// release edge overrides the buffered one.

module pc_unit #(
  parameter int            n        = 32,
  parameter logic [n-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          branch,
  input  logic          jump,
  input  logic          jr,
  input  logic [n-1:0]  imm_sl2,
  input  logic [25:0]   jaddr,
  input  logic [n-1:0]  jr_target,
  output logic [n-1:0]  pc,
  output logic [n-1:0]  pc_plus4,
  output logic          fetch_valid,
  output logic          redirect_pending
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [n-1:0] pc_q, pc_d;
  logic [n-1:0] pend_tgt_q, pend_tgt_d;
  logic [0:0]   state_q, state_d;
  logic         fetch_valid_q, fetch_valid_d;

  logic [n-1:0] br_tgt;
  logic [n-1:0] j_tgt;
  logic [n-1:0] jr_tgt;
  logic [n-1:0] tgt;
  logic         redir;

  assign pc_plus4 = pc_q + n'(4);

  // Target candidates; every add wraps modulo 2^n.
  assign br_tgt = pc_plus4 + imm_sl2;
  assign j_tgt  = {pc_plus4[n-1:28], jaddr, 2'b00};
  // Register jumps are word-aligned by clearing the low two bits.
  assign jr_tgt = jr_target & {{(n-2){1'b1}}, 2'b00};

  assign redir = jr | jump | branch;

  always_comb begin
    tgt = br_tgt;
    if (jr) begin
      tgt = jr_tgt;
    end else if (jump) begin
      tgt = j_tgt;
    end
  end

  always_comb begin
    pc_d          = pc_q;
    pend_tgt_d    = pend_tgt_q;
    state_d       = state_q;
    fetch_valid_d = 1'b1;

    if (!stall) begin
      // A live redirect on the release edge beats whatever is buffered.
      if (redir) begin
        pc_d = tgt;
      end else if (state_q == ST_PEND) begin
        pc_d = pend_tgt_q;
      end else begin
        pc_d = pc_plus4;
      end
      state_d = ST_RUN;
    end else if (redir) begin
      // Stalled: park the redirect; a newer one overwrites an older one.
      pend_tgt_d = tgt;
      state_d    = ST_PEND;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      pend_tgt_q    <= '0;
      state_q       <= ST_RUN;
      fetch_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      pend_tgt_q    <= pend_tgt_d;
      state_q       <= state_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign pc               = pc_q;
  assign fetch_valid      = fetch_valid_q;
  assign redirect_pending = (state_q == ST_PEND);

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit
//   Bench for pc_unit. The driver applies one cycle of inputs on the falling
//   edge, advances a behavioural model of the PC stage and pushes the state
//   expected after the next rising edge into exp_q. A separate monitor pops
//   one entry after every rising edge and compares it with the DUT outputs.
//   Directed scenarios also check a few absolute values.

module tb_pc_unit;

  localparam int N = 32;
  localparam int W = N + 2;              // {fetch_valid, pending, pc}
  localparam logic [N-1:0] RST_PC = 32'h0000_0000;

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic          branch;
  logic          jump;
  logic          jr;
  logic [N-1:0]  imm_sl2;
  logic [25:0]   jaddr;
  logic [N-1:0]  jr_target;
  logic [N-1:0]  pc;
  logic [N-1:0]  pc_plus4;
  logic          fetch_valid;
  logic          redirect_pending;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];

  // Reference model state
  logic [N-1:0] m_pc;
  logic         m_fv;
  logic         m_pend;
  logic [N-1:0] m_saved;

  pc_unit #(.n(N), .RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .branch           (branch),
    .jump             (jump),
    .jr               (jr),
    .imm_sl2          (imm_sl2),
    .jaddr            (jaddr),
    .jr_target        (jr_target),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .fetch_valid      (fetch_valid),
    .redirect_pending (redirect_pending)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Called on a falling edge; returns on the next falling edge.
  task automatic cycle(input logic r_n, input logic st, input logic br, input logic jp,
                       input logic j_r, input logic [N-1:0] imm, input logic [25:0] ja,
                       input logic [N-1:0] jt);
    logic [N-1:0] target;
    logic         take;
    rst_n = r_n; stall = st; branch = br; jump = jp; jr = j_r;
    imm_sl2 = imm; jaddr = ja; jr_target = jt;

    // Model: pick the redirect address from the instruction semantics.
    take = j_r || jp || br;
    if (j_r)
      target = (jt / 4) * 4;
    else if (jp)
      target = ((m_pc + 4) & 32'hF000_0000) + (N'(ja) * 4);
    else
      target = m_pc + 4 + imm;

    if (!r_n) begin
      m_pc = RST_PC; m_fv = 1'b0; m_pend = 1'b0; m_saved = '0;
    end else begin
      m_fv = 1'b1;
      if (st) begin
        if (take) begin
          m_pend  = 1'b1;
          m_saved = target;
        end
      end else begin
        if (take)        m_pc = target;
        else if (m_pend) m_pc = m_saved;
        else             m_pc = m_pc + 4;
        m_pend = 1'b0;
      end
    end
    exp_q.push_back({m_fv, m_pend, m_pc});
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pc",               pc,                            e[N-1:0]);
      check("pc_plus4",         pc_plus4,                      e[N-1:0] + 32'd4);
      check("fetch_valid",      N'(fetch_valid),               N'(e[N+1]));
      check("redirect_pending", N'(redirect_pending),          N'(e[N]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; stall = 1'b0; branch = 1'b0; jump = 1'b0; jr = 1'b0;
    imm_sl2 = '0; jaddr = '0; jr_target = '0;
    m_pc = RST_PC; m_fv = 1'b0; m_pend = 1'b0; m_saved = '0;
    @(negedge clk);

    // Reset two cycles, then free-running sequential fetch.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1234, 26'h55, 32'h99);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    check("reset_pc", pc, 32'h0);
    check("reset_fetch_valid", N'(fetch_valid), 32'h0);
    check("reset_pending", N'(redirect_pending), 32'h0);
    idle(1);
    check("first_fetch_valid", N'(fetch_valid), 32'h1);
    check("seq_pc_4", pc, 32'h4);
    idle(1);
    check("seq_pc_8", pc, 32'h8);

    // Branch at pc=0x8.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, '0, '0);
    check("branch_tgt", pc, 32'h1C);
    idle(1);
    check("after_branch", pc, 32'h20);

    // Stall buffering: branch while stalled, stall held 3 cycles.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, '0, '0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    check("stall_hold_pc", pc, 32'h20);
    check("stall_pending", N'(redirect_pending), 32'h1);
    idle(1);
    check("release_pc", pc, 32'h64);
    check("release_pending", N'(redirect_pending), 32'h0);

    // Live jr on release overrides the buffered target.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, '0, '0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 32'h303);
    check("jr_override_pc", pc, 32'h300);
    check("jr_override_pending", N'(redirect_pending), 32'h0);

    // Reset while pending drops the buffered target.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80, '0, '0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80, '0, '0);
    check("rst_pend_pc", pc, RST_PC);
    check("rst_pend_pending", N'(redirect_pending), 32'h0);
    idle(1);
    check("rst_pend_next", pc, 32'h4);

    // Jump beats branch.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 32'h1000_0040);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h8, 26'h100, '0);
    check("jump_priority", pc, 32'h1000_0400);

    // Wrap-around, then a negative branch offset landing on 0.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 32'hFFFF_FFFC);
    idle(1);
    check("wrap_pc", pc, 32'h0);
    idle(1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, '0, '0);
    check("neg_branch", pc, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) == 0),
            {$urandom_range(0, 1) ? 16'hFFFF : 16'h0000, 14'($urandom()), 2'b00},
            26'($urandom()),
            $urandom());
    end

    idle(2);
    check("scoreboard_drained", N'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
